cheat_code_sequencer: RTL and testbench
=======================================

Name: cheat_code_sequencer

Overview:
- Loads Game Genie–format cheat codes from the host download stream (MiSTer menu file) and writes them into the code table of the cheat evaluator.
- The code table write bus is 38 bits: {strobe[37], index[36:33], enable[32], cmp_en[31], addr[30:16], compare[15:8], replace[7:0]}.
- Arbitrates that bus between the on-screen genie ROM handler (gg_code, highest priority) and host codes.
- Slots INDEX_BASE..INDEX_BASE+MAX_CODES-1 belong to host codes; lower slots stay with the genie ROM.

Parameters:
- INDEX_BASE, 3: first table index used for host codes.
- MAX_CODES, 6: number of host slots; INDEX_BASE+MAX_CODES ≤ 16.
- FIFO_DEPTH, 4: assembled-record buffer depth; power of two.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dl_en  in  1  host cheat download active
- dl_wr  in  1  one-cycle byte strobe, valid only while dl_en=1
- dl_data  in  8  download byte
- clear  in  1  one-cycle pulse: erase all host slots
- gg_code  in  38  code bus from the genie ROM handler
- code  out  38  registered merged code bus to the evaluator
- busy  out  1  high while FIFO is non-empty or state=CLEAR
- num_codes  out  4  host slots written since last clear/reset
- overflow  out  1  sticky: a record was dropped (slots exhausted or FIFO full)
- bad_rec  out  1  sticky checksum error (see Optional Feature)

Behaviour:
- Reset (async): code=0, busy=0, num_codes=0, overflow=0, bad_rec=0; FIFO empty; byte counter=0; state=RUN.
- Record format, 5 bytes in order:
  - b0: bit0 enable, bit1 cmp_en, bits 7:2 ignored.
  - b1: addr[14:8] (bit 7 ignored).
  - b2: addr[7:0].
  - b3: compare.
  - b4: replace.
  - Assembled payload = {b0[0], b0[1], b1[6:0], b2, b3, b4}, 33 bits.
- Byte counter:
  - Advances on each dl_wr.
  - The final byte completes the record, pushes it to the FIFO on the next cycle, and returns the counter to 0.
  - A dl_en falling edge discards any partial record and zeroes the counter.
  - Back-to-back dl_wr every cycle is legal.
- Push rules, applied in order:
  - num_codes + FIFO occupancy == MAX_CODES → drop, set overflow.
  - FIFO full → drop, set overflow.
  - Otherwise push.
- Output mux, registered once per cycle:
  - If gg_code[37]=1, code ← gg_code (pass-through; 1-cycle latency).
  - Else, if state=RUN and FIFO is non-empty: pop, code ← {1, INDEX_BASE+num_codes, payload}, num_codes++.
  - Else code ← 0.
  - Strobe is high exactly one cycle per slot write.
  - Minimum latency from the final byte's dl_wr to its code strobe is 2 cycles.
- State machine RUN/CLEAR:
  - A clear pulse, in any state, enters CLEAR. It flushes the FIFO, zeroes the byte counter, num_codes and overflow, and loads wipe index = INDEX_BASE.
  - In CLEAR, each cycle where gg_code[37]=0 emits {1, wipe_idx, 33'd0} and increments wipe_idx.
  - After slot INDEX_BASE+MAX_CODES-1 is emitted, return to RUN.
  - dl_wr during CLEAR is ignored.
  - A clear received during CLEAR restarts the wipe.
- A clear coincident with a final-byte push: clear wins and the record is discarded.
- A gg_code strobe stalls host emission and the wipe; nothing is lost.
- num_codes saturates at MAX_CODES.

Optional Feature:
- Macro: CHEAT_CHECKSUM_EN.
- Defined: records are 6 bytes, where b5 = XOR of b0..b4. On mismatch the record is dropped, bad_rec is set (cleared by clear/reset), and overflow is unaffected.
- Undefined: records are 5 bytes and bad_rec is tied to 0.

Decomposition:
- Package cheat_pkg holds:
  - CODE_W=38, PAYLOAD_W=33.
  - Bit-position constants for strobe, index, enable, cmp_en, addr, compare, replace.
  - REC_BYTES, which depends on the macro.
  - State enum {ST_RUN, ST_CLEAR}.
- Sub-module cheat_fifo: synchronous FIFO, 33 bits × FIFO_DEPTH, with push, pop, full, empty and count.

Test Plan:
- Download record 01 12 34 00 EA, gg idle → one-cycle code = {1, 4'd3, 1, 0, 15'h1234, 8'h00, 8'hEA} two cycles after the last byte; num_codes=1.
- Stream 7 records back-to-back → slots 3..8 written in order; 7th dropped; overflow=1; num_codes=6.
- Hold gg_code[37]=1 for 3 cycles with 4 records queued → gg_code passes through unchanged; host strobes resume afterward; no record lost.
- Drop dl_en after 3 bytes, then send a full record → only the full record is written, to slot 3.
- After 2 codes, pulse clear → six strobes with indices 3..8 and zero payload; num_codes=0; overflow=0; busy drops after the last strobe.
- With CHEAT_CHECKSUM_EN, send a record with a wrong b5 → no strobe; bad_rec=1. Correct b5 → strobe issued.

Source files
------------

// File: rtl/cheat_pkg.sv
// Shared constants, code-bus layout and state type for the cheat code sequencer.
// Record length depends on CHEAT_CHECKSUM_EN (6 bytes with trailing XOR checksum, else 5).
package cheat_pkg;
  localparam int CODE_W    = 38;
  localparam int PAYLOAD_W = 33;
  localparam int STB_BIT   = 37;
  localparam int IDX_LSB   = 33;
  localparam int IDX_W     = 4;
  localparam int EN_BIT    = 32;
  localparam int CMPEN_BIT = 31;
  localparam int ADDR_LSB  = 16;
  localparam int ADDR_W    = 15;
  localparam int CMP_LSB   = 8;
  localparam int REP_LSB   = 0;
`ifdef CHEAT_CHECKSUM_EN
  localparam int REC_BYTES = 6;
`else
  localparam int REC_BYTES = 5;
`endif

  typedef enum logic {ST_RUN, ST_CLEAR} state_t;

  function automatic logic [CODE_W-1:0] mk_code(input logic [IDX_W-1:0] idx,
                                                input logic [PAYLOAD_W-1:0] pl);
    logic [CODE_W-1:0] c;
    c = '0;
    c[STB_BIT] = 1'b1;
    c[IDX_LSB +: IDX_W] = idx;
    c[PAYLOAD_W-1:0] = pl;
    return c;
  endfunction
endpackage

// File: rtl/cheat_code_sequencer_if.sv
// Host download, clear, genie ROM bus and merged code-table bus of the sequencer.
interface cheat_code_sequencer_if;
  import cheat_pkg::*;
  logic                  dl_en;
  logic                  dl_wr;
  logic [7:0]            dl_data;
  logic                  clear;
  logic [CODE_W-1:0]     gg_code;
  logic [CODE_W-1:0]     code;
  logic                  busy;
  logic [IDX_W-1:0]      num_codes;
  logic                  overflow;
  logic                  bad_rec;

  modport master (output dl_en, dl_wr, dl_data, clear, gg_code,
                  input  code, busy, num_codes, overflow, bad_rec);
  modport slave  (input  dl_en, dl_wr, dl_data, clear, gg_code,
                  output code, busy, num_codes, overflow, bad_rec);
endinterface

// File: rtl/cheat_fifo.sv
// Synchronous FIFO for assembled code records; flush empties it in one cycle.
module cheat_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= din;

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/cheat_code_sequencer.sv
// Assembles host cheat records into table writes, merged behind genie ROM traffic.
// Optional CHEAT_CHECKSUM_EN adds a trailing XOR byte per record and the bad_rec flag.
module cheat_code_sequencer
  import cheat_pkg::*;
#(
  parameter int INDEX_BASE = 3,
  parameter int MAX_CODES  = 6,
  parameter int FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   reset,
  cheat_code_sequencer_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(INDEX_BASE);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(INDEX_BASE + MAX_CODES - 1);
  localparam logic [IDX_W-1:0] MAX_N     = IDX_W'(MAX_CODES);

  state_t                 state, state_n;
  logic [2:0]             cnt;
  logic                   dl_en_q, rec_vld, rec_ok, wr_ok, last_byte;
  logic [PAYLOAD_W-1:0]   asm_q, asm_n, rec_data, fifo_dout;
  logic [IDX_W-1:0]       wipe, wipe_n, num, num_n;
  logic [CODE_W-1:0]      code_q, code_n;
  logic                   push, pop, full, empty, ovf;
  logic [CW-1:0]          occ;

  assign wr_ok     = bus.dl_en && bus.dl_wr && (state == ST_RUN) && !bus.clear;
  assign last_byte = (cnt == 3'(REC_BYTES - 1));

  // Each byte lands directly in its payload field so the final byte completes it in place.
  always_comb begin
    asm_n = asm_q;
    case (cnt)
      3'd0: begin
        asm_n[EN_BIT]    = bus.dl_data[0];
        asm_n[CMPEN_BIT] = bus.dl_data[1];
      end
      3'd1: asm_n[ADDR_LSB+8 +: ADDR_W-8] = bus.dl_data[6:0];
      3'd2: asm_n[ADDR_LSB +: 8]          = bus.dl_data;
      3'd3: asm_n[CMP_LSB +: 8]           = bus.dl_data;
      3'd4: asm_n[REP_LSB +: 8]           = bus.dl_data;
      default: ;
    endcase
  end

`ifdef CHEAT_CHECKSUM_EN
  logic [7:0] csum;
  logic       bad;
  assign rec_ok = (csum == bus.dl_data);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum <= '0;
      bad  <= 1'b0;
    end else begin
      if (wr_ok) csum <= ((cnt == 3'd0) ? 8'h00 : csum) ^ bus.dl_data;
      if (bus.clear)                           bad <= 1'b0;
      else if (wr_ok && last_byte && !rec_ok)  bad <= 1'b1;
    end
  end
  assign bus.bad_rec = bad;
`else
  assign rec_ok      = 1'b1;
  assign bus.bad_rec = 1'b0;
`endif

  // Slot check counts queued records too, so a full table never admits one more.
  assign push = rec_vld && !bus.clear && !full &&
                ((int'(num) + int'(occ)) != MAX_CODES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      dl_en_q  <= 1'b0;
      asm_q    <= '0;
      rec_vld  <= 1'b0;
      rec_data <= '0;
      ovf      <= 1'b0;
    end else begin
      dl_en_q <= bus.dl_en;
      rec_vld <= 1'b0;
      if (bus.clear || (dl_en_q && !bus.dl_en)) begin
        cnt <= '0;
      end else if (wr_ok) begin
        asm_q <= asm_n;
        if (last_byte) begin
          cnt      <= '0;
          rec_vld  <= rec_ok;
          rec_data <= asm_n;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end
      if (bus.clear)             ovf <= 1'b0;
      else if (rec_vld && !push) ovf <= 1'b1;
    end
  end

  cheat_fifo #(.W(PAYLOAD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (bus.clear),
    .push  (push),
    .pop   (pop),
    .din   (rec_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  always_comb begin
    state_n = state;
    wipe_n  = wipe;
    num_n   = num;
    code_n  = '0;
    pop     = 1'b0;
    if (bus.gg_code[STB_BIT]) begin
      code_n = bus.gg_code;
    end else if (state == ST_RUN && !empty) begin
      pop    = 1'b1;
      code_n = mk_code(IDX_FIRST + num, fifo_dout);
      num_n  = (num == MAX_N) ? num : num + 1'b1;
    end else if (state == ST_CLEAR) begin
      code_n = mk_code(wipe, '0);
      wipe_n = wipe + 1'b1;
      if (wipe == IDX_LAST) state_n = ST_RUN;
    end
    // Clear overrides everything except genie pass-through, and restarts any wipe.
    if (bus.clear) begin
      state_n = ST_CLEAR;
      wipe_n  = IDX_FIRST;
      num_n   = '0;
      pop     = 1'b0;
      if (!bus.gg_code[STB_BIT]) code_n = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_RUN;
      wipe   <= IDX_FIRST;
      num    <= '0;
      code_q <= '0;
    end else begin
      state  <= state_n;
      wipe   <= wipe_n;
      num    <= num_n;
      code_q <= code_n;
    end
  end

  assign bus.code      = code_q;
  assign bus.busy      = !empty || (state == ST_CLEAR);
  assign bus.num_codes = num;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_cheat_code_sequencer.sv
// Directed and randomized checks of the cheat code sequencer against a record-level model.
module tb_cheat_code_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cheat_code_sequencer_if bus();
  cheat_code_sequencer #(.INDEX_BASE(3), .MAX_CODES(6), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus));

`ifdef CHEAT_CHECKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif

  int n_checks = 0, n_fail = 0;
  int cyc = 0, last_cyc;
  logic gg_q = 1'b0;
  logic [37:0] seen_code [$];
  int          seen_cyc  [$];
  logic [39:0] exp_rec   [$];

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    gg_q <= bus.gg_code[37];
  end
  // Host-originated strobes only: genie pass-through is checked inline.
  always @(negedge clk)
    if (!reset && bus.code[37] && !gg_q) begin
      seen_code.push_back(bus.code);
      seen_cyc.push_back(cyc);
    end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] rnd_rec();
    return {8'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [37:0] rnd_gg();
    return {1'b1, 5'($urandom), 32'($urandom)};
  endfunction

  // Field-level model: slot number -> table index, record bytes -> code fields.
  function automatic logic [37:0] host_code(input int slot, input logic [39:0] r);
    logic [7:0] b0, b1, b2, b3, b4;
    {b0, b1, b2, b3, b4} = r;
    return {1'b1, 4'(3 + slot), b0[0], b0[1], b1[6:0], b2, b3, b4};
  endfunction

  task automatic send_rec(input logic [39:0] r, input bit bad_ck);
    logic [7:0] bb [6];
    {bb[0], bb[1], bb[2], bb[3], bb[4]} = r;
    bb[5] = bb[0] ^ bb[1] ^ bb[2] ^ bb[3] ^ bb[4] ^ {7'd0, bad_ck};
    for (int i = 0; i < NB; i++) begin
      bus.dl_wr = 1'b1; bus.dl_data = bb[i];
      tick;
    end
    bus.dl_wr = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic drain;
    int k = 0;
    repeat (3) tick;
    while (bus.busy && k < 60) begin tick; k++; end
    chk("drain_timeout", bus.busy, 1'b0);
    repeat (2) tick;
  endtask

  task automatic check_wipe;
    chk("wipe_count", seen_code.size(), 6);
    for (int i = 0; i < seen_code.size() && i < 6; i++) begin
      chk("wipe_code", seen_code[i], {1'b1, 4'(3 + i), 33'd0});
      chk("wipe_cycle", seen_cyc[i], seen_cyc[0] + i);
    end
    chk("wipe_num", bus.num_codes, 0);
    chk("wipe_ovf", bus.overflow, 0);
    chk("wipe_bad", bus.bad_rec, 0);
  endtask

  task automatic do_clear;
    seen_code.delete(); seen_cyc.delete();
    bus.clear = 1'b1; tick; bus.clear = 1'b0;
    chk("clear_busy", bus.busy, 1'b1);
    drain;
    check_wipe;
  endtask

  task automatic check_stream(input string tag, input int n_exp);
    chk({tag, "_count"}, seen_code.size(), n_exp);
    for (int i = 0; i < n_exp && i < seen_code.size(); i++)
      chk({tag, "_code"}, seen_code[i], host_code(i, exp_rec[i]));
  endtask

  initial begin
    logic [39:0] r;
    logic [37:0] g;
    int n, gap;
    bus.dl_en = 0; bus.dl_wr = 0; bus.dl_data = 0; bus.clear = 0; bus.gg_code = '0;
    reset = 1'b1;
    repeat (3) tick;
    reset = 1'b0;
    tick;
    chk("rst_code", bus.code, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_num", bus.num_codes, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_bad", bus.bad_rec, 0);
    bus.dl_en = 1'b1; tick;

    // Directed record with fixed expectation and 2-cycle latency.
    seen_code.delete(); seen_cyc.delete();
    send_rec(40'h01_12_34_00_EA, 1'b0);
    n = last_cyc;
    drain;
    chk("first_count", seen_code.size(), 1);
    if (seen_code.size() >= 1) begin
      chk("first_code", seen_code[0], {1'b1, 4'd3, 1'b1, 1'b0, 15'h1234, 8'h00, 8'hEA});
      chk("first_latency", seen_cyc[0], n + 2);
    end
    chk("first_num", bus.num_codes, 1);

    seen_code.delete(); seen_cyc.delete();
    r = rnd_rec(); send_rec(r, 1'b0); drain;
    chk("second_count", seen_code.size(), 1);
    if (seen_code.size() >= 1) chk("second_code", seen_code[0], host_code(1, r));
    chk("second_num", bus.num_codes, 2);
    do_clear;

    // Seven back-to-back records: six slots, then a drop.
    seen_code.delete(); seen_cyc.delete(); exp_rec.delete();
    for (int i = 0; i < 7; i++) begin r = rnd_rec(); exp_rec.push_back(r); send_rec(r, 1'b0); end
    drain;
    check_stream("b2b", 6);
    chk("b2b_ovf", bus.overflow, 1);
    chk("b2b_num", bus.num_codes, 6);
    do_clear;

    // Partial record abandoned by dl_en falling.
    seen_code.delete(); seen_cyc.delete(); exp_rec.delete();
    for (int i = 0; i < 3; i++) begin bus.dl_wr = 1; bus.dl_data = 8'($urandom); tick; end
    bus.dl_wr = 0; bus.dl_en = 0; tick; bus.dl_en = 1; tick;
    r = rnd_rec(); exp_rec.push_back(r); send_rec(r, 1'b0); drain;
    check_stream("partial", 1);
    chk("partial_num", bus.num_codes, 1);
    do_clear;

    // Genie strobes stall host emission and pass straight through.
    seen_code.delete(); seen_cyc.delete(); exp_rec.delete();
    g = rnd_gg(); bus.gg_code = g;
    for (int i = 0; i < 4; i++) begin r = rnd_rec(); exp_rec.push_back(r); send_rec(r, 1'b0); end
    chk("gg_busy", bus.busy, 1);
    chk("gg_num", bus.num_codes, 0);
    chk("gg_no_host", seen_code.size(), 0);
    chk("gg_pass0", bus.code, g);
    for (int k = 0; k < 3; k++) begin
      g = rnd_gg(); bus.gg_code = g; tick;
      chk("gg_pass", bus.code, g);
    end
    bus.gg_code = '0;
    drain;
    check_stream("gg_resume", 4);
    chk("gg_resume_num", bus.num_codes, 4);

    // Clear on the same cycle as a record's final byte.
    seen_code.delete(); seen_cyc.delete();
    r = rnd_rec();
    for (int i = 0; i < NB; i++) begin
      bus.dl_wr = 1; bus.dl_data = (i < 5) ? r[39 - 8*i -: 8] : 8'h00;
      if (i == NB - 1) begin
        bus.dl_data = r[39:32] ^ r[31:24] ^ r[23:16] ^ r[15:8] ^ r[7:0];
        if (NB == 5) bus.dl_data = r[7:0];
        bus.clear = 1;
      end
      tick;
    end
    bus.dl_wr = 0; bus.clear = 0;
    drain;
    check_wipe;

    // Randomized rounds with gaps and single-cycle genie strobes.
    for (int rnd = 0; rnd < 3; rnd++) begin
      do_clear;
      seen_code.delete(); seen_cyc.delete(); exp_rec.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        r = rnd_rec(); exp_rec.push_back(r); send_rec(r, 1'b0);
        gap = $urandom_range(0, 2);
        for (int k = 0; k < gap; k++) begin
          if ($urandom_range(0, 2) == 0) bus.gg_code = rnd_gg();
          tick;
          bus.gg_code = '0;
        end
      end
      drain;
      check_stream("rand", (n > 6) ? 6 : n);
      chk("rand_ovf", bus.overflow, (n > 6) ? 1 : 0);
      chk("rand_num", bus.num_codes, (n > 6) ? 6 : n);
    end

`ifdef CHEAT_CHECKSUM_EN
    do_clear;
    seen_code.delete(); seen_cyc.delete(); exp_rec.delete();
    send_rec(rnd_rec(), 1'b1); drain;
    chk("ck_bad_count", seen_code.size(), 0);
    chk("ck_bad_flag", bus.bad_rec, 1);
    chk("ck_bad_ovf", bus.overflow, 0);
    r = rnd_rec(); exp_rec.push_back(r); send_rec(r, 1'b0); drain;
    check_stream("ck_good", 1);
    do_clear;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
